// File: rtl/seq_arith_pkg.sv
// Shared opcodes and FSM state encoding for the sequential arithmetic unit.
package seq_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

endpackage

// File: rtl/seq_add_sub_w.sv
// W-bit adder/subtractor; subtraction inverts i_b, caller supplies the +1 via i_cin.
module seq_add_sub_w #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_sub,
  input  logic             i_cin,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  logic [WIDTH:0] w_full;

  assign w_full = {1'b0, i_a} + {1'b0, i_b ^ {WIDTH{i_sub}}} + {{WIDTH{1'b0}}, i_cin};
  assign o_sum  = w_full[WIDTH-1:0];
  assign o_cout = w_full[WIDTH];

endmodule

// File: rtl/seq_arith_control.sv
// One-bit-per-clock unsigned add / multiply / divide with a start/done handshake.
module seq_arith_control
  import seq_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic [WIDTH-1:0] out_high,
  output logic [WIDTH-1:0] out_low,
  output logic             flag,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_add_a;
  logic [WIDTH-1:0]   w_add_b;
  logic               w_add_sub;
  logic               w_add_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic               w_carry_nxt;

  // Divide: remainder shifted left with the next dividend bit (MSB of the low half).
  assign w_rem_sh = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};

  // Shared adder operand steering per operation.
  always_comb begin
    w_add_a   = r_acc[2*WIDTH-1:WIDTH];
    w_add_b   = r_op_a;
    w_add_sub = 1'b0;
    w_add_cin = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_add_a   = WIDTH'(r_op_a[0]);
        w_add_b   = WIDTH'(r_op_b[0]);
        w_add_cin = r_carry;
      end
      OP_DIV: begin
        w_add_a   = w_rem_sh[WIDTH-1:0];
        w_add_b   = r_op_b;
        w_add_sub = 1'b1;
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  seq_add_sub_w #(.WIDTH(WIDTH)) u_add_sub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_add_sub),
    .i_cin (w_add_cin),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  // Next accumulator value for one step of the selected operation.
  always_comb begin
    w_acc_nxt   = r_acc;
    w_carry_nxt = r_carry;
    w_ge        = 1'b0;
    case (r_op)
      OP_ADD: begin
        w_acc_nxt   = {r_acc[2*WIDTH-1:WIDTH], w_sum[0], r_acc[WIDTH-1:1]};
        w_carry_nxt = w_sum[1];
      end
      OP_MUL: begin
        if (r_acc[0]) w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};
        else          w_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
      end
      OP_DIV: begin
        // A set shifted-out MSB means the trial remainder already exceeds any divisor.
        w_ge      = w_rem_sh[WIDTH] | w_cout;
        w_acc_nxt = {(w_ge ? w_sum : w_rem_sh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_ge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_op     <= OP_ADD;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      out_high <= '0;
      out_low  <= '0;
      flag     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            r_state <= RUN;
            done    <= 1'b0;
            r_op    <= op;
            r_op_a  <= in1;
            r_op_b  <= in2;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            case (op)
              OP_MUL:  r_acc <= {{WIDTH{1'b0}}, in2};
              OP_DIV:  r_acc <= {{WIDTH{1'b0}}, in1};
              default: r_acc <= '0;
            endcase
          end
        end
        RUN: begin
          r_acc   <= w_acc_nxt;
          r_carry <= w_carry_nxt;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_op == OP_ADD) begin
            r_op_a <= r_op_a >> 1;
            r_op_b <= r_op_b >> 1;
          end
          if (r_cnt == CNT_W'(WIDTH - 1)) begin
            r_state <= DONE;
            done    <= 1'b1;
            case (r_op)
              OP_ADD: begin
                out_high <= '0;
                out_low  <= w_acc_nxt[WIDTH-1:0];
                flag     <= w_carry_nxt;
              end
              OP_MUL: begin
                out_high <= w_acc_nxt[2*WIDTH-1:WIDTH];
                out_low  <= w_acc_nxt[WIDTH-1:0];
                flag     <= 1'b0;
              end
              OP_DIV: begin
                out_high <= w_acc_nxt[2*WIDTH-1:WIDTH];
                out_low  <= w_acc_nxt[WIDTH-1:0];
                flag     <= (r_op_b == '0);
              end
              default: begin
                out_high <= '0;
                out_low  <= '0;
                flag     <= 1'b1;
              end
            endcase
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_arith_control.sv
// Randomized and directed bench for seq_arith_control against an arithmetic reference model.
module tb_seq_arith_control;

  localparam int unsigned W   = 4;
  localparam int unsigned MOD = 2 ** W;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op    = 2'b00;
  logic [W-1:0] in1   = '0;
  logic [W-1:0] in2   = '0;
  logic [W-1:0] out_high;
  logic [W-1:0] out_low;
  logic         flag;
  logic         done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_arith_control #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .in1     (in1),
    .in2     (in2),
    .out_high(out_high),
    .out_low (out_low),
    .flag    (flag),
    .done    (done)
  );

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         fl;
  } res_t;

  function automatic res_t ref_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned ai;
    int unsigned bi;
    int unsigned s;
    res_t r;
    ai = a;
    bi = b;
    r  = '0;
    case (o)
      2'b00: begin
        s    = ai + bi;
        r.lo = W'(s % MOD);
        r.fl = (s >= MOD);
      end
      2'b01: begin
        s    = ai * bi;
        r.hi = W'(s / MOD);
        r.lo = W'(s % MOD);
      end
      2'b10: begin
        if (bi == 0) begin
          r.hi = a;
          r.lo = '1;
          r.fl = 1'b1;
        end else begin
          r.hi = W'(ai % bi);
          r.lo = W'(ai / bi);
        end
      end
      default: r.fl = 1'b1;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a busy countdown of W edges after an accepted start, then the arithmetic result.
  res_t m_out  = '0;
  res_t m_pend = '0;
  logic m_done = 1'b0;
  int   m_left = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out  = '0;
      m_done = 1'b0;
      m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_out  = m_pend;
        m_done = 1'b1;
      end
    end else if (start) begin
      m_pend = ref_op(op, in1, in2);
      m_left = W;
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("done",     32'(done),     32'(m_done));
    check("out_high", 32'(out_high), 32'(m_out.hi));
    check("out_low",  32'(out_low),  32'(m_out.lo));
    check("flag",     32'(flag),     32'(m_out.fl));
  end

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask

  // Launch one operation; with noise, scramble inputs and toggle start while running.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit noise, output int lat);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    in1   = a;
    in2   = b;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    if (noise) begin
      op  = 2'($urandom);
      in1 = W'($urandom);
      in2 = W'($urandom);
    end
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
      if (!done && noise) start = 1'($urandom % 2);
    end
    start = 1'b0;
    if (!done) check("done_timeout", 32'(done), 32'd1);
  endtask

  int lat;

  initial begin
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", 32'(done), 32'd0);
    check("rst_high", 32'(out_high), 32'd0);
    check("rst_low",  32'(out_low), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    #2 reset = 1'b1;

    run_op(2'b00, 4'd9, 4'd8, 1'b0, lat);
    check("add9_8_lat", 32'(lat), 32'd4);
    check("add9_8_low", 32'(out_low), 32'h1);
    check("add9_8_flag", 32'(flag), 32'd1);
    check("add9_8_high", 32'(out_high), 32'h0);
    run_op(2'b00, 4'd3, 4'd4, 1'b1, lat);
    check("add3_4_low", 32'(out_low), 32'h7);
    check("add3_4_flag", 32'(flag), 32'd0);

    run_op(2'b01, 4'd15, 4'd15, 1'b1, lat);
    check("mul15_15_high", 32'(out_high), 32'hE);
    check("mul15_15_low", 32'(out_low), 32'h1);
    check("mul15_15_flag", 32'(flag), 32'd0);
    run_op(2'b01, 4'd0, 4'd9, 1'b0, lat);
    check("mul0_9_high", 32'(out_high), 32'h0);
    check("mul0_9_low", 32'(out_low), 32'h0);

    run_op(2'b10, 4'd13, 4'd4, 1'b1, lat);
    check("div13_4_q", 32'(out_low), 32'h3);
    check("div13_4_r", 32'(out_high), 32'h1);
    check("div13_4_flag", 32'(flag), 32'd0);
    run_op(2'b10, 4'd3, 4'd7, 1'b0, lat);
    check("div3_7_q", 32'(out_low), 32'h0);
    check("div3_7_r", 32'(out_high), 32'h3);

    run_op(2'b10, 4'd7, 4'd0, 1'b0, lat);
    check("div7_0_lat", 32'(lat), 32'd4);
    check("div7_0_q", 32'(out_low), 32'hF);
    check("div7_0_r", 32'(out_high), 32'h7);
    check("div7_0_flag", 32'(flag), 32'd1);

    run_op(2'b11, 4'd5, 4'd6, 1'b0, lat);
    check("rsv_lat", 32'(lat), 32'd4);
    check("rsv_out", 32'({out_high, out_low}), 32'h0);
    check("rsv_flag", 32'(flag), 32'd1);

    // Abort a multiply two cycles in, then confirm a fresh start still computes correctly.
    run_op(2'b01, 4'd9, 4'd9, 1'b0, lat);
    @(negedge clk);
    start = 1'b1;
    op    = 2'b01;
    in1   = 4'd7;
    in2   = 4'd6;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("abort_done", 32'(done), 32'd0);
    check("abort_out", 32'({out_high, out_low}), 32'h0);
    check("abort_flag", 32'(flag), 32'd0);
    #2 reset = 1'b1;
    run_op(2'b01, 4'd7, 4'd6, 1'b0, lat);
    check("mul7_6_high", 32'(out_high), 32'h2);
    check("mul7_6_low", 32'(out_low), 32'hA);

    for (int o = 0; o < 3; o++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          pulse_reset();
          run_op(2'(o), 4'(a), 4'(b), 1'b1, lat);
          check("sweep_lat", 32'(lat), 32'd4);
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
      end
    end

    for (int i = 0; i < 300; i++) begin
      run_op(2'($urandom), W'($urandom), W'($urandom), 1'($urandom % 2), lat);
      check("rand_lat", 32'(lat), 32'd4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d failures so far", n_fail);
    $fatal(1);
  end

endmodule
